// File: rtl/ex_mem_stage_pkg.sv
// rtl/ex_mem_stage_pkg.sv - shared types and FSM encodings for the EX/MEM stage
package ex_mem_stage_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  // Writeback source select carried through to MEM/WB
  typedef enum logic [1:0] {
    SEL_RESULT = 2'd0,
    SEL_DLOAD  = 2'd1,
    SEL_NPC    = 2'd2
  } mem_to_reg_mux_selection;

  // Stage FSM encoding
  typedef logic [0:0] ex_mem_state_t;
  localparam ex_mem_state_t IDLE   = 1'b0;
  localparam ex_mem_state_t ACCESS = 1'b1;

endpackage

// File: rtl/ex_mem_stage_sat_counter.sv
// rtl/ex_mem_stage_sat_counter.sv - saturating up-counter used for stall tracking
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX = '1;

  // Count up on inc, stick at all-ones, clear synchronously on clr
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with dcache request handling
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    enable_EX_MEM,
  input  logic                    flush_EX_MEM,
  input  logic                    dREN_ID_EX,
  input  logic                    dWEN_ID_EX,
  input  logic                    WEN_ID_EX,
  input  logic                    halt_ID_EX,
  input  mem_to_reg_mux_selection mem_to_reg_ID_EX,
  input  regbits_t                wsel_ID_EX,
  input  word_t                   alu_result,
  input  word_t                   store_data,
  input  word_t                   next_imemaddr_ID_EX,
  input  logic                    dhit,
  input  word_t                   dmemload,
  output logic                    dmemREN,
  output logic                    dmemWEN,
  output word_t                   dmemaddr,
  output word_t                   dmemstore,
  output logic                    mem_busy,
  output logic                    WEN_EX_MEM,
  output regbits_t                wsel_EX_MEM,
  output mem_to_reg_mux_selection mem_to_reg_EX_MEM,
  output logic                    halt_EX_MEM,
  output word_t                   result_EX_MEM,
  output word_t                   dload_EX_MEM,
  output word_t                   next_imemaddr_EX_MEM,
  output logic [STALL_CNT_W-1:0]  stall_count
);

  ex_mem_state_t state;
  ex_mem_state_t state_n;
  logic          flush_pend;
  logic          dren_q;
  logic          dwen_q;
  word_t         store_q;

  logic in_access;
  logic done;
  logic do_flush;
  logic do_capture;
  logic new_mem;
  logic is_load;

  assign in_access = (state == ACCESS);
  assign mem_busy  = in_access & ~dhit;
  assign done      = in_access & dhit;

  // A flush seen while waiting is deferred until the access completes
  assign do_flush   = ~mem_busy & (flush_EX_MEM | (done & flush_pend));
  assign do_capture = ~mem_busy & ~do_flush & enable_EX_MEM & ~halt_EX_MEM;
  assign new_mem    = ~halt_ID_EX & (dREN_ID_EX | dWEN_ID_EX);

  // Store wins when both requests are latched
  assign is_load   = dren_q & ~dwen_q;
  assign dmemREN   = in_access & is_load;
  assign dmemWEN   = in_access & dwen_q;
  assign dmemaddr  = result_EX_MEM;
  assign dmemstore = store_q;

  // Next-state: capture decides ACCESS vs IDLE, completion or bubble returns to IDLE
  always_comb begin
    state_n = state;
    if (do_capture) begin
      state_n = new_mem ? ACCESS : IDLE;
    end else if (done || do_flush) begin
      state_n = IDLE;
    end
  end

  // State and deferred-flush flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
    end else begin
      state <= state_n;
      if (mem_busy && flush_EX_MEM) begin
        flush_pend <= 1'b1;
      end else if (done) begin
        flush_pend <= 1'b0;
      end
    end
  end

  // Pipeline register: load data on hit, then bubble or capture of the next instruction
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dren_q               <= 1'b0;
      dwen_q               <= 1'b0;
      store_q              <= '0;
      WEN_EX_MEM           <= 1'b0;
      wsel_EX_MEM          <= '0;
      mem_to_reg_EX_MEM    <= SEL_RESULT;
      halt_EX_MEM          <= 1'b0;
      result_EX_MEM        <= '0;
      dload_EX_MEM         <= '0;
      next_imemaddr_EX_MEM <= '0;
    end else begin
      if (done && is_load) begin
        dload_EX_MEM <= dmemload;
      end
      if (do_flush) begin
        // Halt stays sticky; everything else becomes a bubble, discarding load data
        dren_q               <= 1'b0;
        dwen_q               <= 1'b0;
        store_q              <= '0;
        WEN_EX_MEM           <= 1'b0;
        wsel_EX_MEM          <= '0;
        mem_to_reg_EX_MEM    <= SEL_RESULT;
        result_EX_MEM        <= '0;
        dload_EX_MEM         <= '0;
        next_imemaddr_EX_MEM <= '0;
      end else if (do_capture) begin
        dren_q               <= dREN_ID_EX & ~halt_ID_EX;
        dwen_q               <= dWEN_ID_EX & ~halt_ID_EX;
        store_q              <= store_data;
        WEN_EX_MEM           <= WEN_ID_EX;
        wsel_EX_MEM          <= wsel_ID_EX;
        mem_to_reg_EX_MEM    <= mem_to_reg_ID_EX;
        halt_EX_MEM          <= halt_ID_EX;
        result_EX_MEM        <= alu_result;
        next_imemaddr_EX_MEM <= next_imemaddr_ID_EX;
      end
    end
  end

  sat_counter #(
    .WIDTH(STALL_CNT_W)
  ) u_stall_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .inc  (mem_busy),
    .clr  (1'b0),
    .count(stall_count)
  );

endmodule
